cdr_phase_tracker: RTL and testbench
====================================

CDR_PHASE_TRACKER -- requirements
Module: cdr_phase_tracker

Interface
REQ-001 SHALL have parameter VOTE_TH, default 8, net opposing edge votes that trigger a phase switch (range 2..31).
REQ-002 SHALL have parameter ACQ_WORDS, default 16, number of words accumulated in ACQUIRE.
REQ-003 SHALL have parameter IDLE_WORDS, default 64, consecutive transition-free words that drop lock.
REQ-004 clk  in  1  clock; rising edge only.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  qualifies in_data, one-cycle pulse from the 2x sampler.
REQ-007 in_data  in  4  samples, chronological s0 (bit0, pos) .. s3 (bit3, neg); s0/s2 = POS phase, s1/s3 = NEG phase.
REQ-008 out_valid  out  1  recovered word strobe.
REQ-009 out_data  out  2  recovered bits, bit0 oldest.
REQ-010 out_nbits  out  2  valid bits in out_data: 1 or 2.
REQ-011 locked  out  1  high in LOCKED state.
REQ-012 phase_sel  out  1  0 = POS, 1 = NEG.
REQ-013 slip  out  1  one-cycle pulse when a phase switch takes effect.

Function
REQ-014 SHALL act only on cycles with in_valid=1; all state holds otherwise.
REQ-015 Per word SHALL compute cA = transitions s0->s1 plus s2->s3, cB = transitions s1->s2 plus prev_s3->s0; prev_s3 term excluded on first word after reset or ACQUIRE entry.
REQ-016 cA votes for NEG, cB votes for POS.
REQ-017 FSM states ACQUIRE, LOCKED; reset state ACQUIRE.
REQ-018 ACQUIRE: signed acc += cA-cB for ACQ_WORDS words; then phase_sel = (acc>0 ? NEG : POS), acc cleared, go LOCKED; out_valid held 0.
REQ-019 LOCKED: 6-bit unsigned opp_cnt += votes for other phase, -= votes for current phase, clamped to 0..63.
REQ-020 opp_cnt >= VOTE_TH SHALL toggle phase_sel, clear opp_cnt, pulse slip; the toggle applies from the next accepted word.
REQ-021 LOCKED, normal word: out_valid=1 one cycle after in_valid, out_data = {s2,s0} (POS) or {s3,s1} (NEG), out_nbits=2.
REQ-022 First word after NEG->POS switch: drop s0, out_data = {0,s2}, out_nbits=1.
REQ-023 First word after POS->NEG switch: normal 2-bit output.
REQ-024 idle_cnt counts consecutive words with cA+cB=0, clears on any transition; reaching IDLE_WORDS in LOCKED SHALL go ACQUIRE, clear counters, deassert locked same cycle as transition.
REQ-025 Switch threshold and idle loss on same word: idle loss wins, no slip pulse.
REQ-026 Latency in_valid -> out_valid exactly 1 cycle; at most one out_valid per in_valid.
REQ-027 Counters (acc, opp_cnt, idle_cnt) SHALL saturate, never wrap.

Reset
REQ-028 On rst_n low: state ACQUIRE, out_valid 0, out_data 0, out_nbits 0, locked 0, phase_sel 0, slip 0, all counters 0, prev_s3 invalid.
REQ-029 Reset mid-word SHALL discard partial vote and suppress any pending out_valid.
REQ-030 Deassertion SHALL be synchronized by the instantiating level; block assumes synchronous release.

Structure
REQ-031 Package cdr_pkg SHALL hold state enum (ACQUIRE, LOCKED), phase enum (PHASE_POS, PHASE_NEG), and counter widths.
REQ-032 Sub-module cdr_edge_vote SHALL be combinational: in_data, prev_s3, prev_valid -> cA, cB.
REQ-033 Total RTL 120-400 lines, single clock domain.

Verification
REQ-034 16 words 4'b0110 after reset -> cA=2, cB=0 each; after 16th, locked=1, phase_sel=NEG; next word out_data=2'b01, out_nbits=2.
REQ-035 Locked POS, feed 4 words with cA=2,cB=0 (VOTE_TH=8) -> slip pulse on 4th, phase_sel=NEG, following word uses s1/s3.
REQ-036 Locked NEG, drive cB-dominant words to switch -> first POS word out_nbits=1, out_data=2'b0s2.
REQ-037 Locked, 64 words of 4'b0000 -> locked drops on 64th, out_valid stays 0 thereafter until re-acquire.
REQ-038 Assert rst_n low during LOCKED with in_valid=1 -> all outputs 0 immediately, no out_valid next cycle.
REQ-039 Random in_valid gaps (0-3 cycles) -> output stream identical to gapless run.

Source files
------------

// File: rtl/cdr_pkg.sv
// Shared types and counter widths for the 2x-oversampled CDR phase tracker.
package cdr_pkg;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } cdr_state_e;

  typedef enum logic {
    PHASE_POS = 1'b0,
    PHASE_NEG = 1'b1
  } cdr_phase_e;

  localparam int VOTE_W = 2;
  localparam int ACC_W  = 8;
  localparam int OPP_W  = 6;
  localparam int IDLE_W = 8;
  localparam int WCNT_W = 8;

  localparam int ACC_MAX  = (2 ** (ACC_W - 1)) - 1;
  localparam int ACC_MIN  = -(2 ** (ACC_W - 1));
  localparam int OPP_MAX  = (2 ** OPP_W) - 1;
  localparam int IDLE_MAX = (2 ** IDLE_W) - 1;

endpackage

// File: rtl/cdr_edge_vote.sv
// Counts data transitions in one 4-sample word: c_a favours the NEG phase,
// c_b favours POS. The boundary term against the previous word needs a valid history.
module cdr_edge_vote
  import cdr_pkg::*;
(
  input  logic [3:0]        in_data,
  input  logic              prev_s3,
  input  logic              prev_valid,
  output logic [VOTE_W-1:0] c_a,
  output logic [VOTE_W-1:0] c_b
);

  always_comb begin
    c_a = {1'b0, in_data[0] ^ in_data[1]} + {1'b0, in_data[2] ^ in_data[3]};
    c_b = {1'b0, in_data[1] ^ in_data[2]} + {1'b0, prev_valid & (prev_s3 ^ in_data[0])};
  end

endmodule

// File: rtl/cdr_phase_tracker.sv
// Bang-bang phase tracker for a 2x sampler: acquires a phase by majority vote,
// then tracks it with a hysteresis counter and drops lock after a long idle run.
module cdr_phase_tracker
  import cdr_pkg::*;
#(
  parameter int VOTE_TH    = 8,
  parameter int ACQ_WORDS  = 16,
  parameter int IDLE_WORDS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       out_valid,
  output logic [1:0] out_data,
  output logic [1:0] out_nbits,
  output logic       locked,
  output logic       phase_sel,
  output logic       slip
);

  cdr_state_e               state_q, state_d;
  cdr_phase_e               phase_q, phase_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
  logic [OPP_W-1:0]         opp_q, opp_d;
  logic [IDLE_W-1:0]        idle_q, idle_d;
  logic                     prev_s3_q, prev_s3_d;
  logic                     prev_valid_q, prev_valid_d;
  logic                     drop_q, drop_d;
  logic                     out_valid_q, out_valid_d;
  logic [1:0]               out_data_q, out_data_d;
  logic [1:0]               out_nbits_q, out_nbits_d;
  logic                     slip_q, slip_d;

  logic [VOTE_W-1:0]        c_a, c_b;
  logic [VOTE_W-1:0]        other_v, own_v;
  int                       acc_i, opp_i, idle_i;

  cdr_edge_vote u_edge_vote (
    .in_data    (in_data),
    .prev_s3    (prev_s3_q),
    .prev_valid (prev_valid_q),
    .c_a        (c_a),
    .c_b        (c_b)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    acc_d        = acc_q;
    wcnt_d       = wcnt_q;
    opp_d        = opp_q;
    idle_d       = idle_q;
    prev_s3_d    = prev_s3_q;
    prev_valid_d = prev_valid_q;
    drop_d       = drop_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_nbits_d  = out_nbits_q;
    slip_d       = 1'b0;
    other_v      = '0;
    own_v        = '0;
    acc_i        = 0;
    opp_i        = 0;
    idle_i       = 0;

    if (in_valid) begin
      prev_s3_d    = in_data[3];
      prev_valid_d = 1'b1;

      case (state_q)
        ACQUIRE: begin
          acc_i = int'(acc_q) + int'(c_a) - int'(c_b);
          if (acc_i > ACC_MAX) acc_i = ACC_MAX;
          else if (acc_i < ACC_MIN) acc_i = ACC_MIN;

          if (int'(wcnt_q) >= ACQ_WORDS - 1) begin
            state_d = LOCKED;
            phase_d = (acc_i > 0) ? PHASE_NEG : PHASE_POS;
            acc_d   = '0;
            wcnt_d  = '0;
            opp_d   = '0;
            idle_d  = '0;
            drop_d  = 1'b0;
          end else begin
            acc_d  = ACC_W'(acc_i);
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end

        LOCKED: begin
          other_v = (phase_q == PHASE_POS) ? c_a : c_b;
          own_v   = (phase_q == PHASE_POS) ? c_b : c_a;
          opp_i   = int'(opp_q) + int'(other_v) - int'(own_v);
          if (opp_i > OPP_MAX) opp_i = OPP_MAX;
          else if (opp_i < 0) opp_i = 0;

          idle_i = (c_a == '0 && c_b == '0) ? int'(idle_q) + 1 : 0;
          if (idle_i > IDLE_MAX) idle_i = IDLE_MAX;

          // Idle loss takes priority over a phase switch on the same word
          if (idle_i >= IDLE_WORDS) begin
            state_d      = ACQUIRE;
            acc_d        = '0;
            wcnt_d       = '0;
            opp_d        = '0;
            idle_d       = '0;
            drop_d       = 1'b0;
            prev_valid_d = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            idle_d      = IDLE_W'(idle_i);
            drop_d      = 1'b0;
            if (phase_q == PHASE_NEG) begin
              out_data_d  = {in_data[3], in_data[1]};
              out_nbits_d = 2'd2;
            end else if (drop_q) begin
              out_data_d  = {1'b0, in_data[2]};
              out_nbits_d = 2'd1;
            end else begin
              out_data_d  = {in_data[2], in_data[0]};
              out_nbits_d = 2'd2;
            end

            // Moving NEG->POS skips ahead half a bit, so s0 of the next word repeats a bit already sent
            if (opp_i >= VOTE_TH) begin
              phase_d = (phase_q == PHASE_POS) ? PHASE_NEG : PHASE_POS;
              opp_d   = '0;
              slip_d  = 1'b1;
              drop_d  = (phase_q == PHASE_NEG);
            end else begin
              opp_d = OPP_W'(opp_i);
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACQUIRE;
      phase_q      <= PHASE_POS;
      acc_q        <= '0;
      wcnt_q       <= '0;
      opp_q        <= '0;
      idle_q       <= '0;
      prev_s3_q    <= 1'b0;
      prev_valid_q <= 1'b0;
      drop_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_nbits_q  <= '0;
      slip_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      acc_q        <= acc_d;
      wcnt_q       <= wcnt_d;
      opp_q        <= opp_d;
      idle_q       <= idle_d;
      prev_s3_q    <= prev_s3_d;
      prev_valid_q <= prev_valid_d;
      drop_q       <= drop_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_nbits_q  <= out_nbits_d;
      slip_q       <= slip_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_nbits = out_nbits_q;
  assign locked    = (state_q == LOCKED);
  assign phase_sel = phase_q;
  assign slip      = slip_q;

endmodule

// File: tb/tb_cdr_phase_tracker.sv
// Directed-vector bench for cdr_phase_tracker; expected values are hand-derived
// transition counts for each word pattern.
module tb_cdr_phase_tracker;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_valid;
  logic [1:0] out_data;
  logic [1:0] out_nbits;
  logic       locked;
  logic       phase_sel;
  logic       slip;

  int vectors;
  int miscompares;

  cdr_phase_tracker #(
    .VOTE_TH    (8),
    .ACQ_WORDS  (16),
    .IDLE_WORDS (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_nbits (out_nbits),
    .locked    (locked),
    .phase_sel (phase_sel),
    .slip      (slip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One accepted word; returns on the following falling edge with outputs settled
  task automatic apply_word(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_data  = 4'b0110;
    @(negedge clk);
    vectors++;
    if ({out_valid, out_data, out_nbits, locked, phase_sel, slip} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b expected %b",
               {out_valid, out_data, out_nbits, locked, phase_sel, slip}, 8'h00);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_acquire_lock();
    for (int i = 0; i < 16; i++) begin
      apply_word(4'b0110);
      if (i < 15) begin
        vectors++;
        if ({locked, out_valid} !== 2'b00) begin
          miscompares++;
          $display("[TB] FAIL acquire_word%0d: got locked/valid %b expected 00", i, {locked, out_valid});
        end
      end
    end
    vectors++;
    if ({locked, phase_sel, out_valid} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL acquire_done: got locked/phase/valid %b expected 110", {locked, phase_sel, out_valid});
    end
    apply_word(4'b0110);
    vectors++;
    if ({out_valid, out_data, out_nbits, slip} !== {1'b1, 2'b01, 2'd2, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL first_locked_word: got %b expected %b",
               {out_valid, out_data, out_nbits, slip}, {1'b1, 2'b01, 2'd2, 1'b0});
    end
  endtask

  task automatic test_switch_neg_to_pos();
    for (int i = 0; i < 4; i++) begin
      apply_word(4'b0011);
      vectors++;
      if ({out_valid, out_data, out_nbits, slip} !== {1'b1, 2'b01, 2'd2, (i == 3)}) begin
        miscompares++;
        $display("[TB] FAIL neg2pos_word%0d: got %b expected %b", i,
                 {out_valid, out_data, out_nbits, slip}, {1'b1, 2'b01, 2'd2, (i == 3)});
      end
    end
    vectors++;
    if (phase_sel !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL neg2pos_phase: got %b expected 0", phase_sel);
    end
    apply_word(4'b0100);
    vectors++;
    if ({out_valid, out_data, out_nbits, slip} !== {1'b1, 2'b01, 2'd1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL neg2pos_dropped_word: got %b expected %b",
               {out_valid, out_data, out_nbits, slip}, {1'b1, 2'b01, 2'd1, 1'b0});
    end
    apply_word(4'b0100);
    vectors++;
    if ({out_valid, out_data, out_nbits} !== {1'b1, 2'b10, 2'd2}) begin
      miscompares++;
      $display("[TB] FAIL neg2pos_normal_word: got %b expected %b",
               {out_valid, out_data, out_nbits}, {1'b1, 2'b10, 2'd2});
    end
  endtask

  task automatic test_switch_pos_to_neg();
    for (int i = 0; i < 4; i++) begin
      apply_word(4'b0110);
      vectors++;
      if ({out_valid, out_data, out_nbits, slip} !== {1'b1, 2'b10, 2'd2, (i == 3)}) begin
        miscompares++;
        $display("[TB] FAIL pos2neg_word%0d: got %b expected %b", i,
                 {out_valid, out_data, out_nbits, slip}, {1'b1, 2'b10, 2'd2, (i == 3)});
      end
    end
    vectors++;
    if (phase_sel !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pos2neg_phase: got %b expected 1", phase_sel);
    end
    apply_word(4'b0110);
    vectors++;
    if ({out_valid, out_data, out_nbits, slip} !== {1'b1, 2'b01, 2'd2, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL pos2neg_first_word: got %b expected %b",
               {out_valid, out_data, out_nbits, slip}, {1'b1, 2'b01, 2'd2, 1'b0});
    end
  endtask

  task automatic test_idle_loss();
    for (int i = 0; i < 63; i++) begin
      apply_word(4'b0000);
      vectors++;
      if ({locked, out_valid, out_data} !== 4'b1100) begin
        miscompares++;
        $display("[TB] FAIL idle_word%0d: got locked/valid/data %b expected 1100", i, {locked, out_valid, out_data});
      end
    end
    apply_word(4'b0000);
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_loss: got locked %b expected 0", locked);
    end
    // Re-acquire: only the first word carries a vote if the boundary term is excluded
    apply_word(4'b0001);
    for (int i = 0; i < 15; i++) begin
      vectors++;
      if ({locked, out_valid} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL reacquire_word%0d: got locked/valid %b expected 00", i, {locked, out_valid});
      end
      apply_word(4'b0000);
    end
    vectors++;
    if ({locked, phase_sel, out_valid} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL reacquire_done: got locked/phase/valid %b expected 110", {locked, phase_sel, out_valid});
    end
  endtask

  task automatic test_reset_mid_word();
    in_valid = 1'b1;
    in_data  = 4'b0110;
    @(negedge clk);
    vectors++;
    if ({out_valid, out_data, locked} !== {1'b1, 2'b01, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_word: got %b expected %b", {out_valid, out_data, locked}, {1'b1, 2'b01, 1'b1});
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_data, out_nbits, locked, phase_sel, slip} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL async_reset_outputs: got %b expected %b",
               {out_valid, out_data, out_nbits, locked, phase_sel, slip}, 8'h00);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_pending_valid: got %b expected 0", out_valid);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    vectors++;
    if ({out_valid, locked} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL post_reset_idle: got valid/locked %b expected 00", {out_valid, locked});
    end
  endtask

  task automatic test_first_word_exclusion();
    apply_word(4'b0001);
    for (int i = 0; i < 15; i++) apply_word(4'b0000);
    vectors++;
    if ({locked, phase_sel} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL first_word_exclusion: got locked/phase %b expected 11", {locked, phase_sel});
    end
  endtask

  task automatic test_back_to_back_gaps();
    logic [3:0] words [6] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0100, 4'b0100};
    logic [1:0] exp_d [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    logic [1:0] exp_n [6] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};
    logic       exp_s [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int gap;
    for (int i = 0; i < 6; i++) begin
      apply_word(words[i]);
      vectors++;
      if ({out_valid, out_data, out_nbits, slip} !== {1'b1, exp_d[i], exp_n[i], exp_s[i]}) begin
        miscompares++;
        $display("[TB] FAIL gap_word%0d: got %b expected %b", i,
                 {out_valid, out_data, out_nbits, slip}, {1'b1, exp_d[i], exp_n[i], exp_s[i]});
      end
      gap = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        vectors++;
        if ({out_valid, slip} !== 2'b00) begin
          miscompares++;
          $display("[TB] FAIL gap_idle%0d_%0d: got valid/slip %b expected 00", i, g, {out_valid, slip});
        end
      end
    end
    vectors++;
    if ({locked, phase_sel} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL gap_final_phase: got locked/phase %b expected 10", {locked, phase_sel});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 4'b0000;
    repeat (2) @(negedge clk);

    test_reset();
    test_acquire_lock();
    test_switch_neg_to_pos();
    test_switch_pos_to_neg();
    test_idle_loss();
    test_reset_mid_word();
    test_first_word_exclusion();
    test_back_to_back_gaps();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
